ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter_if.sv | 64 ++++++
 rtl/ram_port_arbiter.sv | 112 +++++++++++
 tb/tb_ram_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Bundle of request, data-stream and RAM-controller signals around the arbiter.
// The arbiter uses the slave modport; the surrounding system drives the master side.
interface ram_port_arbiter_if #(
    parameter int AddrWidth = 21,
    parameter int WordWidth = 16,
    parameter int LenWidth  = 16
);
    // image-capture write requester
    logic                 w_req;
    logic [AddrWidth-1:0] w_addr;
    logic [LenWidth-1:0]  w_len;
    logic                 w_ack;
    logic [WordWidth-1:0] w_data;
    logic                 w_data_valid;
    logic                 w_data_ready;

    // readout requester
    logic                 r_req;
    logic [AddrWidth-1:0] r_addr;
    logic [LenWidth-1:0]  r_len;
    logic                 r_ack;
    logic [WordWidth-1:0] r_data;
    logic                 r_data_valid;
    logic                 r_data_ready;

    // RAM controller side
    logic                 ram_cmd_trigger;
    logic                 ram_cmd_ready;
    logic                 ram_cmd_write;
    logic [AddrWidth-1:0] ram_cmd_addr;
    logic [WordWidth-1:0] ram_wdata;
    logic                 ram_wdata_valid;
    logic                 ram_wdata_ready;
    logic [WordWidth-1:0] ram_rdata;
    logic                 ram_rdata_valid;
    logic                 ram_rdata_ready;

    logic                 busy;
    logic                 owner;

    modport slave (
        input  w_req, w_addr, w_len, w_data, w_data_valid,
        output w_ack, w_data_ready,
        input  r_req, r_addr, r_len, r_data_ready,
        output r_ack, r_data, r_data_valid,
        output ram_cmd_trigger, ram_cmd_write, ram_cmd_addr,
        input  ram_cmd_ready,
        output ram_wdata, ram_wdata_valid, ram_rdata_ready,
        input  ram_wdata_ready, ram_rdata, ram_rdata_valid,
        output busy, owner
    );

    modport master (
        output w_req, w_addr, w_len, w_data, w_data_valid,
        input  w_ack, w_data_ready,
        output r_req, r_addr, r_len, r_data_ready,
        input  r_ack, r_data, r_data_valid,
        input  ram_cmd_trigger, ram_cmd_write, ram_cmd_addr,
        output ram_cmd_ready,
        input  ram_wdata, ram_wdata_valid, ram_rdata_ready,
        output ram_wdata_ready, ram_rdata, ram_rdata_valid,
        input  busy, owner
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester block arbiter in front of a single-port RAM controller: one command
// per block, then the owner's data stream is passed straight through until N words move.
module ram_port_arbiter #(
    parameter int AddrWidth = 21,
    parameter int WordWidth = 16,
    parameter int LenWidth  = 16
) (
    input logic              clk,
    input logic              rst,
    ram_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_XFER
    } state_t;

    state_t               state_reg;
    logic                 owner_reg;
    logic                 rr_reg;
    logic                 trigger_reg;
    logic                 busy_reg;
    logic [AddrWidth-1:0] addr_reg;
    logic [LenWidth-1:0]  len_reg;
    logic [LenWidth-1:0]  count_reg;

    logic any_req;
    logic grant_read;
    logic cmd_fire;
    logic wr_xfer;
    logic rd_xfer;
    logic beat;
    logic last_beat;

    always_comb begin
        any_req    = bus.w_req | bus.r_req;
        // rr_reg = 1 means read has priority when both ask in the same cycle
        grant_read = bus.r_req & (~bus.w_req | rr_reg);
        cmd_fire   = (state_reg == ST_CMD) & trigger_reg & bus.ram_cmd_ready;
        wr_xfer    = (state_reg == ST_XFER) & ~owner_reg;
        rd_xfer    = (state_reg == ST_XFER) & owner_reg;
        beat       = (wr_xfer & bus.w_data_valid & bus.ram_wdata_ready)
                   | (rd_xfer & bus.ram_rdata_valid & bus.r_data_ready);
        // compare before increment so an all-ones length never wraps early
        last_beat  = beat & (count_reg == len_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            owner_reg   <= 1'b0;
            rr_reg      <= 1'b0;
            trigger_reg <= 1'b0;
            busy_reg    <= 1'b0;
            addr_reg    <= '0;
            len_reg     <= '0;
            count_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        owner_reg   <= grant_read;
                        addr_reg    <= grant_read ? bus.r_addr : bus.w_addr;
                        len_reg     <= grant_read ? bus.r_len : bus.w_len;
                        trigger_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (cmd_fire) begin
                        trigger_reg <= 1'b0;
                        count_reg   <= '0;
                        state_reg   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (last_beat) begin
                        busy_reg  <= 1'b0;
                        rr_reg    <= ~owner_reg;
                        state_reg <= ST_IDLE;
                    end else if (beat) begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                default: begin
                    trigger_reg <= 1'b0;
                    busy_reg    <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy            = busy_reg;
    assign bus.owner           = owner_reg;
    assign bus.ram_cmd_trigger = trigger_reg;
    assign bus.ram_cmd_write   = trigger_reg & ~owner_reg;
    assign bus.ram_cmd_addr    = addr_reg;
    assign bus.w_ack           = cmd_fire & ~owner_reg;
    assign bus.r_ack           = cmd_fire & owner_reg;

    // Data words ride through unregistered; only the handshakes are gated by ownership.
    assign bus.ram_wdata       = bus.w_data;
    assign bus.ram_wdata_valid = wr_xfer & bus.w_data_valid;
    assign bus.w_data_ready    = wr_xfer & bus.ram_wdata_ready;
    assign bus.r_data          = bus.ram_rdata;
    assign bus.r_data_valid    = rd_xfer & bus.ram_rdata_valid;
    assign bus.ram_rdata_ready = rd_xfer & bus.r_data_ready;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: table of single-block vectors, hand sequences for
// reset/arbitration corners, and a randomized two-requester run against a block-level model.
module tb_ram_port_arbiter;

    localparam int AW = 21;
    localparam int WW = 16;
    localparam int LW = 16;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   n_txn;
    bit   dut_order_q[$];

    ram_port_arbiter_if #(.AddrWidth(AW), .WordWidth(WW), .LenWidth(LW)) bus ();

    ram_port_arbiter #(.AddrWidth(AW), .WordWidth(WW), .LenWidth(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit            rd;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        int            cmd_wait;
        int            stall;
        bit            glitch;
        bit            exp_write;
        int            exp_beats;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [WW-1:0] word_of(input logic [AW-1:0] a, input int idx);
        logic [WW-1:0] mix;
        mix = 16'(idx * 40503);
        return a[15:0] ^ a[20:5] ^ mix ^ 16'h5A5A;
    endfunction

    function automatic logic [8:0] outs_vec();
        return {bus.busy, bus.owner, bus.ram_cmd_trigger, bus.w_ack, bus.r_ack,
                bus.w_data_ready, bus.ram_wdata_valid, bus.r_data_valid, bus.ram_rdata_ready};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.w_req = 0; bus.w_addr = '0; bus.w_len = '0;
        bus.w_data = '0; bus.w_data_valid = 0;
        bus.r_req = 0; bus.r_addr = '0; bus.r_len = '0; bus.r_data_ready = 0;
        bus.ram_cmd_ready = 0; bus.ram_wdata_ready = 0;
        bus.ram_rdata = '0; bus.ram_rdata_valid = 0;
    endtask

    task automatic do_reset();
        step();
        drive_idle();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    // One block from a single requester; returns after two idle cycles past the last beat.
    task automatic run_block(input vec_t v);
        int  beats;
        int  dut_beats;
        int  guard;
        bit  prod;
        bit  cons;
        step();
        drive_idle();
        if (v.rd) begin
            bus.r_req = 1; bus.r_addr = v.addr; bus.r_len = v.len;
        end else begin
            bus.w_req = 1; bus.w_addr = v.addr; bus.w_len = v.len;
        end
        #1;
        check("idle_before_req", bus.busy, 0);
        for (int k = 0; k <= v.cmd_wait; k++) begin
            step();
            bus.ram_cmd_ready = (k == v.cmd_wait);
            #1;
            check("cmd_trigger", bus.ram_cmd_trigger, 1);
            check("cmd_write", bus.ram_cmd_write, v.exp_write);
            check("cmd_addr", bus.ram_cmd_addr, v.addr);
            check("owner_ack", v.rd ? bus.r_ack : bus.w_ack, (k == v.cmd_wait));
            check("other_ack", v.rd ? bus.w_ack : bus.r_ack, 0);
        end
        beats = 0;
        dut_beats = 0;
        guard = 0;
        while (beats < int'(v.len) + 1 && guard < 200000) begin
            step();
            guard++;
            bus.w_req = 0; bus.r_req = 0; bus.ram_cmd_ready = 0;
            if (v.glitch) bus.r_req = (guard == 1);
            case (v.stall)
                0: begin prod = 1; cons = 1; end
                1: begin prod = 1; cons = guard[0]; end
                default: begin prod = 1'($urandom_range(1)); cons = 1'($urandom_range(1)); end
            endcase
            if (v.rd) begin
                bus.ram_rdata_valid = prod; bus.r_data_ready = cons;
                bus.ram_rdata = word_of(v.addr, beats);
            end else begin
                bus.w_data_valid = prod; bus.ram_wdata_ready = cons;
                bus.w_data = word_of(v.addr, beats);
            end
            #1;
            check("no_ack_in_xfer", {bus.w_ack, bus.r_ack}, 0);
            if (v.rd) begin
                check("rd_valid_pass", bus.r_data_valid, prod);
                check("rd_ready_mirror", bus.ram_rdata_ready, cons);
                check("wr_side_low", {bus.w_data_ready, bus.ram_wdata_valid}, 0);
                if (bus.r_data_valid && bus.r_data_ready) dut_beats++;
                if (prod && cons) begin
                    check("rd_word", bus.r_data, word_of(v.addr, beats));
                    beats++;
                end
            end else begin
                check("wr_valid_pass", bus.ram_wdata_valid, prod);
                check("wr_ready_pass", bus.w_data_ready, cons);
                check("rd_side_low", {bus.r_data_valid, bus.ram_rdata_ready}, 0);
                if (bus.ram_wdata_valid && bus.ram_wdata_ready) dut_beats++;
                if (prod && cons) begin
                    check("wr_word", bus.ram_wdata, word_of(v.addr, beats));
                    beats++;
                end
            end
        end
        if (guard >= 200000) fail_now("xfer_guard");
        step();
        drive_idle();
        #1;
        check("busy_after_last", bus.busy, 0);
        check("trigger_after_last", bus.ram_cmd_trigger, 0);
        step();
        #1;
        check("still_idle", {bus.busy, bus.ram_cmd_trigger}, 0);
        check("beat_count", dut_beats, v.exp_beats);
        n_txn++;
        $display("txn %0d %s addr=%06h len=%0d beats=%0d", n_txn, v.rd ? "read " : "write",
                 v.addr, v.len, dut_beats);
    endtask

    // Two free-running requesters against a block-level model of arbitration and transfer.
    task automatic run_random(input int ncyc, input int prob, input int max_len);
        int            ph;
        bit            m_own;
        bit            m_rr;
        bit            w_pend;
        bit            r_pend;
        bit            b;
        logic [AW-1:0] m_addr;
        logic [LW-1:0] m_len;
        logic [LW-1:0] m_cnt;
        ph = 0; m_own = 0; m_rr = 0; w_pend = 0; r_pend = 0;
        m_addr = '0; m_len = '0; m_cnt = '0;
        dut_order_q.delete();
        for (int c = 0; c < ncyc; c++) begin
            step();
            if (!w_pend) begin
                bus.w_req = 0;
                if ($urandom_range(99) < prob) begin
                    w_pend = 1; bus.w_req = 1;
                    bus.w_addr = AW'($urandom); bus.w_len = LW'($urandom_range(0, max_len));
                end
            end
            if (!r_pend) begin
                bus.r_req = 0;
                if ($urandom_range(99) < prob) begin
                    r_pend = 1; bus.r_req = 1;
                    bus.r_addr = AW'($urandom); bus.r_len = LW'($urandom_range(0, max_len));
                end
            end
            bus.ram_cmd_ready   = ($urandom_range(3) != 0);
            bus.w_data_valid    = 1'($urandom_range(1));
            bus.w_data          = WW'($urandom);
            bus.ram_wdata_ready = 1'($urandom_range(1));
            bus.ram_rdata_valid = 1'($urandom_range(1));
            bus.ram_rdata       = word_of(m_addr, int'(m_cnt));
            bus.r_data_ready    = 1'($urandom_range(1));
            #1;
            case (ph)
                0: begin
                    check("rnd_idle_outs", outs_vec() & 9'h17F, 0);
                    if (bus.w_req || bus.r_req) begin
                        m_own  = (bus.w_req && bus.r_req) ? m_rr : bus.r_req;
                        m_addr = m_own ? bus.r_addr : bus.w_addr;
                        m_len  = m_own ? bus.r_len : bus.w_len;
                        ph = 1;
                    end
                end
                1: begin
                    check("rnd_cmd", {bus.ram_cmd_trigger, bus.ram_cmd_write, bus.owner, bus.busy},
                          {1'b1, ~m_own, m_own, 1'b1});
                    check("rnd_cmd_addr", bus.ram_cmd_addr, m_addr);
                    check("rnd_ack", {bus.w_ack, bus.r_ack},
                          bus.ram_cmd_ready ? (m_own ? 2'b01 : 2'b10) : 2'b00);
                    check("rnd_cmd_data_low", outs_vec() & 9'h00F, 0);
                    if (bus.w_ack || bus.r_ack) dut_order_q.push_back(bus.ram_cmd_write);
                    if (bus.ram_cmd_ready) begin
                        ph = 2; m_cnt = '0;
                        if (m_own) r_pend = 0; else w_pend = 0;
                        n_txn++;
                        $display("txn %0d %s addr=%06h len=%0d (random)", n_txn,
                                 m_own ? "read " : "write", m_addr, m_len);
                    end
                end
                default: begin
                    check("rnd_xfer_busy", {bus.busy, bus.owner, bus.ram_cmd_trigger},
                          {1'b1, m_own, 1'b0});
                    if (!m_own) begin
                        check("rnd_wr_pass", {bus.ram_wdata_valid, bus.w_data_ready,
                              bus.r_data_valid, bus.ram_rdata_ready},
                              {bus.w_data_valid, bus.ram_wdata_ready, 2'b00});
                        b = bus.w_data_valid && bus.ram_wdata_ready;
                        if (b) check("rnd_wr_word", bus.ram_wdata, bus.w_data);
                    end else begin
                        check("rnd_rd_pass", {bus.r_data_valid, bus.ram_rdata_ready,
                              bus.ram_wdata_valid, bus.w_data_ready},
                              {bus.ram_rdata_valid, bus.r_data_ready, 2'b00});
                        b = bus.ram_rdata_valid && bus.r_data_ready;
                        if (b) check("rnd_rd_word", bus.r_data, word_of(m_addr, int'(m_cnt)));
                    end
                    if (b) begin
                        if (m_cnt == m_len) begin
                            ph = 0; m_rr = ~m_own;
                        end else begin
                            m_cnt = m_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        n_cmp = 0; n_bad = 0; n_txn = 0;
        tbl[0] = '{rd:0, addr:21'h00100, len:16'd3, cmd_wait:0,  stall:0, glitch:0, exp_write:1, exp_beats:4};
        tbl[1] = '{rd:1, addr:21'h02000, len:16'd7, cmd_wait:0,  stall:1, glitch:0, exp_write:0, exp_beats:8};
        tbl[2] = '{rd:0, addr:21'h1FFFFF, len:16'd0, cmd_wait:2, stall:2, glitch:0, exp_write:1, exp_beats:1};
        tbl[3] = '{rd:1, addr:21'h00000, len:16'd0, cmd_wait:0,  stall:0, glitch:0, exp_write:0, exp_beats:1};
        tbl[4] = '{rd:0, addr:21'h0F0F0, len:16'd5, cmd_wait:20, stall:2, glitch:0, exp_write:1, exp_beats:6};
        tbl[5] = '{rd:1, addr:21'h15555, len:16'd4, cmd_wait:1,  stall:2, glitch:0, exp_write:0, exp_beats:5};
        tbl[6] = '{rd:0, addr:21'h00200, len:16'd3, cmd_wait:0,  stall:0, glitch:1, exp_write:1, exp_beats:4};

        rst = 1;
        drive_idle();
        bus.w_data_valid = 1; bus.ram_wdata_ready = 1;
        bus.ram_rdata_valid = 1; bus.r_data_ready = 1; bus.ram_cmd_ready = 1;
        step();
        step();
        #1;
        check("reset_outputs", outs_vec(), 0);
        rst = 0;
        drive_idle();

        for (int i = 0; i < 7; i++) run_block(tbl[i]);

        // reset on the third beat of a 16-word write
        do_reset();
        step();
        bus.w_req = 1; bus.w_addr = 21'h0ABCD; bus.w_len = 16'd15; bus.ram_cmd_ready = 1;
        step();
        #1;
        check("rst_seq_ack", bus.w_ack, 1);
        step();
        bus.w_req = 0; bus.w_data_valid = 1; bus.ram_wdata_ready = 1;
        bus.ram_rdata_valid = 1; bus.r_data_ready = 1;
        step();
        step();
        rst = 1;
        #1;
        check("beat3_active", bus.w_data_ready, 1);
        step();
        rst = 0;
        #1;
        check("post_rst_outputs", outs_vec(), 0);
        step();
        #1;
        check("post_rst_quiet", outs_vec(), 0);
        step();
        drive_idle();
        bus.w_req = 1; bus.w_addr = 21'h00300; bus.w_len = 16'd1;
        bus.r_req = 1; bus.r_addr = 21'h00400; bus.r_len = 16'd1;
        step();
        #1;
        check("rr_write_after_rst", {bus.ram_cmd_trigger, bus.ram_cmd_write}, 2'b11);
        do_reset();
        rv = '{rd:1, addr:21'h00444, len:16'd2, cmd_wait:0, stall:0, glitch:0, exp_write:0, exp_beats:3};
        run_block(rv);

        // both requesters always pending: blocks alternate write, read, write, read
        do_reset();
        run_random(300, 100, 2);
        if (dut_order_q.size() < 4) fail_now("alternation_blocks");
        else begin
            check("order0_write", dut_order_q[0], 1);
            check("order1_read", dut_order_q[1], 0);
            check("order2_write", dut_order_q[2], 1);
            check("order3_read", dut_order_q[3], 0);
        end

        do_reset();
        run_random(3000, 30, 6);

        // maximum length: 65536 words
        do_reset();
        rv = '{rd:0, addr:21'h10000, len:16'hFFFF, cmd_wait:0, stall:0, glitch:0, exp_write:1, exp_beats:65536};
        run_block(rv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
